// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: the frame FSM state
// encoding, the default bit period and the data width.
// Ports: none (package).
//------------------------------------------------------------------------------
package uart_pkg;

  // Number of data bits in every frame.
  localparam int DATA_WIDTH = 8;

  // Default bit period in system clocks; both link ends must agree on it.
  localparam int CLKS_PER_BIT_DEFAULT = 32;

  // Frame sequencer states, in the order they appear on the line.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Parity over one data byte; odd = 1 inverts the even-parity result.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous byte FIFO that buffers bytes between the valid/ready
// input handshake and the transmit sequencer.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset, empties the FIFO
//   push   in   write din this edge (ignored while full)
//   pop    in   drop the head entry this edge (ignored while empty)
//   din    in   byte to write
//   dout   out  current head entry (valid while !empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  number of stored entries, 0..DEPTH
//------------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// uart_tx
// UART transmitter. Bytes arrive over a valid/ready handshake into a FIFO and
// are sent as: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset; abandons any frame
//   tx_data     in   byte to transmit
//   tx_valid    in   tx_data valid; accepted when tx_valid && tx_ready
//   tx_ready    out  FIFO not full
//   Tx          out  serial line, idles high, registered
//   tx_busy     out  frame in progress or bytes waiting
//   fifo_count  out  bytes waiting in the FIFO (excludes the byte on the line)
//------------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         Tx,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_WIDTH - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       ODD_SEL   = (PARITY_ODD != 0);

  uart_state_e           state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [2:0]            bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parity_q;
  logic                  tx_q;
  logic                  tx_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  baud_end;
  logic                  stop_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && !fifo_full;
  assign baud_end  = (baud_q == BAUD_LAST);
  assign stop_done = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);
  // Popping at the last stop-bit clock lets the next start bit follow with no gap.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || stop_done);

  // Line level for the current state; registered below, so Tx trails the
  // state by one clock uniformly and every bit keeps its full length.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame sequencer. The baud counter restarts at every bit boundary; bit_q
  // counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (fifo_pop) begin
        shift_q  <= fifo_dout;
        parity_q <= parity_bit(fifo_dout, ODD_SEL);
      end
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (fifo_pop) begin
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q   <= '0;
              state_q <= fifo_pop ? START : IDLE;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign Tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Instance A uses the default framing
// (even parity, one stop bit); instance B has no parity and two stop bits.
// Both run at 32 clocks per bit.
//------------------------------------------------------------------------------
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] txDataA  = 8'h00;
  logic       txValidA = 1'b0;
  logic       txReadyA;
  logic       txA;
  logic       txBusyA;
  logic [2:0] fifoCountA;

  logic [7:0] txDataB  = 8'h00;
  logic       txValidB = 1'b0;
  logic       txReadyB;
  logic       txB;
  logic       txBusyB;
  logic [2:0] fifoCountB;

  int testsRun    = 0;
  int testsFailed = 0;

  // Expected frames, first line bit in the MSB: start, 8 data LSB first, then
  // parity+stop (A) or two stops (B).
  logic [10:0] expA[$];
  logic [10:0] expB[$];
  longint      startLogA[$];
  longint      startLogB[$];

  logic        monActive [2];
  int          monCnt    [2];
  int          monBits   [2];
  logic [10:0] monFrame  [2];

  logic [7:0]  t4Data  [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
  logic [10:0] t4Frame [6] = '{11'b0_10000000_1_1, 11'b0_01000000_1_1,
                               11'b0_11000000_0_1, 11'b0_00100000_1_1,
                               11'b0_10100000_0_1, 11'b0_01100000_0_1};

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (32),
    .PARITY_EN    (1),
    .PARITY_ODD   (0),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dutA (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (txDataA),
    .tx_valid   (txValidA),
    .tx_ready   (txReadyA),
    .Tx         (txA),
    .tx_busy    (txBusyA),
    .fifo_count (fifoCountA)
  );

  uart_tx #(
    .CLKS_PER_BIT (32),
    .PARITY_EN    (0),
    .PARITY_ODD   (0),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (4)
  ) dutB (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (txDataB),
    .tx_valid   (txValidB),
    .tx_ready   (txReadyB),
    .Tx         (txB),
    .tx_busy    (txBusyB),
    .fifo_count (fifoCountB)
  );

  // One comparison: count it, and report a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // A decoded frame is matched against the oldest expected frame of its line.
  task automatic compareFrame(input int m, input logic [10:0] got);
    logic [10:0] want;
    if ((m == 0 && expA.size() == 0) || (m == 1 && expB.size() == 0)) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL unexpected frame on line %0d: got %b, none queued", m, got);
    end else begin
      if (m == 0) want = expA.pop_front();
      else        want = expB.pop_front();
      checkOutput((m == 0) ? "frame A" : "frame B", 32'(got), 32'(want));
    end
  endtask

  // Monitor: on each falling clock edge, detect a start bit on an idle line,
  // then sample every bit in its middle. Reset abandons a frame in progress.
  initial begin
    logic lineBit;
    for (int m = 0; m < 2; m++) begin
      monActive[m] = 1'b0;
      monCnt[m]    = 0;
      monBits[m]   = 0;
      monFrame[m]  = '0;
    end
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        lineBit = (m == 0) ? txA : txB;
        if (rst) begin
          monActive[m] = 1'b0;
        end else if (!monActive[m]) begin
          if (lineBit == 1'b0) begin
            monActive[m] = 1'b1;
            monCnt[m]    = 0;
            monBits[m]   = 0;
            monFrame[m]  = '0;
            if (m == 0) startLogA.push_back($time);
            else        startLogB.push_back($time);
          end
        end else begin
          monCnt[m]++;
          if (monCnt[m] == 16 + 32 * monBits[m]) begin
            monFrame[m] = {monFrame[m][9:0], lineBit};
            monBits[m]++;
            if (monBits[m] == 11) begin
              monActive[m] = 1'b0;
              compareFrame(m, monFrame[m]);
            end
          end
        end
      end
    end
  end

  // Offer one byte, wait (bounded) for ready, queue its expected frame and
  // drop valid right after the accepting edge.
  task automatic applyStimulus(input int which, input logic [7:0] data,
                               input logic [10:0] frame);
    int n = 0;
    @(negedge clk);
    if (which == 0) begin txDataA = data; txValidA = 1'b1; end
    else            begin txDataB = data; txValidB = 1'b1; end
    while (!((which == 0) ? txReadyA : txReadyB) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept timeout: got ready=0, expected ready=1 within 2000 clks");
    end else begin
      if (which == 0) expA.push_back(frame);
      else            expB.push_back(frame);
      @(negedge clk);
    end
    txValidA = 1'b0;
    txValidB = 1'b0;
  endtask

  // Wait (bounded) until every queued frame was seen, then let the line idle.
  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((expA.size() != 0 || expB.size() != 0 || monActive[0] || monActive[1])
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " drained"}, 32'(expA.size() + expB.size()), 0);
    repeat (40) @(negedge clk);
  endtask

  // Directed tests in sequence.
  initial begin
    int bad;
    int lat;
    int idx;
    int iter;
    int iter5;
    int iter6;
    logic willAccept;

    // Test 1: reset held 300 ns, then idle with no writes.
    repeat (15) @(negedge clk);
    checkOutput("T1 Tx in reset", 32'(txA), 1);
    checkOutput("T1 busy in reset", 32'(txBusyA), 0);
    checkOutput("T1 ready in reset", 32'(txReadyA), 1);
    checkOutput("T1 count in reset", 32'(fifoCountA), 0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (txA !== 1'b1 || txBusyA !== 1'b0 || txReadyA !== 1'b1) bad++;
    end
    checkOutput("T1 idle cycles with wrong outputs", 32'(bad), 0);

    // Test 2: 0x90, Tx must fall two edges after the accept.
    applyStimulus(0, 8'h90, 11'b0_00001001_0_1);
    lat = 1;
    while (txA !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("T2 start latency", 32'(lat - 1), 2);
    waitDrain("T2", 1000);

    // Test 3: 0x75 then 0x91 back to back; starts exactly one frame apart.
    startLogA.delete();
    applyStimulus(0, 8'h75, 11'b0_10101110_1_1);
    applyStimulus(0, 8'h91, 11'b0_10001001_1_1);
    waitDrain("T3", 1500);
    checkOutput("T3 frame starts", 32'(startLogA.size()), 2);
    if (startLogA.size() >= 2)
      checkOutput("T3 start spacing", 32'(startLogA[1] - startLogA[0]), 3520);

    // Test 4: six bytes with valid held high into a 4-deep FIFO.
    idx = 0; iter = 0; iter5 = 0; iter6 = 0;
    @(negedge clk);
    txDataA  = t4Data[0];
    txValidA = 1'b1;
    while (idx < 6 && iter < 3000) begin
      willAccept = txReadyA;
      @(negedge clk);
      iter++;
      if (willAccept) begin
        expA.push_back(t4Frame[idx]);
        idx++;
        if (idx == 5) begin
          iter5 = iter;
          checkOutput("T4 count when full", 32'(fifoCountA), 4);
          checkOutput("T4 ready when full", 32'(txReadyA), 0);
        end
        if (idx == 6) begin
          iter6    = iter;
          txValidA = 1'b0;
        end else begin
          txDataA = t4Data[idx];
        end
      end
    end
    txValidA = 1'b0;
    checkOutput("T4 bytes accepted", 32'(idx), 6);
    checkOutput("T4 ready-low gap", 32'(iter6 - iter5), 350);
    waitDrain("T4", 3000);

    // Test 5: no parity, two stop bits, two 0x00 frames 352 clocks apart.
    startLogB.delete();
    applyStimulus(1, 8'h00, 11'b0_00000000_1_1);
    applyStimulus(1, 8'h00, 11'b0_00000000_1_1);
    waitDrain("T5", 1500);
    checkOutput("T5 frame starts", 32'(startLogB.size()), 2);
    if (startLogB.size() >= 2)
      checkOutput("T5 frame length", 32'(startLogB[1] - startLogB[0]), 3520);

    // Test 6: reset in the middle of 0xA5 with two bytes queued.
    applyStimulus(0, 8'hA5, 11'b0_10100101_0_1);
    applyStimulus(0, 8'h11, 11'b0_10001000_0_1);
    applyStimulus(0, 8'h22, 11'b0_01000100_0_1);
    repeat (70) @(negedge clk);
    checkOutput("T6 Tx low in data bit 1", 32'(txA), 0);
    checkOutput("T6 count before reset", 32'(fifoCountA), 2);
    checkOutput("T6 busy before reset", 32'(txBusyA), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("T6 Tx right after reset", 32'(txA), 1);
    checkOutput("T6 count right after reset", 32'(fifoCountA), 0);
    checkOutput("T6 busy right after reset", 32'(txBusyA), 0);
    checkOutput("T6 ready right after reset", 32'(txReadyA), 1);
    expA.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 8'h3C, 11'b0_00111100_0_1);
    waitDrain("T6", 1000);

    // Quiet tail: any stray frame would show up as unexpected here.
    repeat (500) @(negedge clk);
    checkOutput("final queues empty", 32'(expA.size() + expB.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
